// File: rtl/dds_wavegen_pkg.sv
// Shared types, default widths and the sine table generator for dds_wavegen.
package dds_pkg;

    typedef enum logic [1:0] {
        MODE_SINE = 2'd0,
        MODE_SAW  = 2'd1,
        MODE_TRI  = 2'd2,
        MODE_SQR  = 2'd3
    } mode_e;

    localparam int DDS_ACC_W  = 32;
    localparam int DDS_ADDR_W = 12;
    localparam int DDS_DATA_W = 14;
    localparam int DDS_LAT    = 3;

    // Offset-binary sine sample for table index idx, built with Bhaskara's
    // rational approximation so the table is a pure elaboration-time constant.
    function automatic longint sine_sample(input longint idx, input int addr_w, input int data_w);
        longint half;
        longint mid;
        longint amp;
        longint p;
        longint q;
        longint mag;
        half = 64'sd1 << (addr_w - 1);
        mid  = 64'sd1 << (data_w - 1);
        amp  = mid - 64'sd1;
        p    = (idx >= half) ? (idx - half) : idx;
        q    = p * (half - p);
        mag  = (amp * 64'sd16 * q) / ((64'sd5 * half * half) - (64'sd4 * q));
        if (idx >= half) begin
            return mid - mag;
        end else begin
            return mid + mag;
        end
    endfunction

endpackage

// File: rtl/dds_wavegen_if.sv
// Configuration and sample bus of the DDS waveform generator.
interface dds_wavegen_if
    import dds_pkg::*;
#(
    parameter int ACC_W  = DDS_ACC_W,
    parameter int ADDR_W = DDS_ADDR_W,
    parameter int DATA_W = DDS_DATA_W
);
    logic              en;
    logic              cfg_load;
    logic [ACC_W-1:0]  cfg_ftw;
    logic [ADDR_W-1:0] cfg_poff;
    logic [1:0]        cfg_mode;
    logic [ADDR_W-1:0] cfg_duty;
    logic              cfg_busy;
    logic [DATA_W-1:0] wave;
    logic              wave_valid;
    logic              sync;

    modport master (
        output en, cfg_load, cfg_ftw, cfg_poff, cfg_mode, cfg_duty,
        input  cfg_busy, wave, wave_valid, sync
    );

    modport slave (
        input  en, cfg_load, cfg_ftw, cfg_poff, cfg_mode, cfg_duty,
        output cfg_busy, wave, wave_valid, sync
    );
endinterface

// File: rtl/dds_sine_rom.sv
// Sine table with registered address and unregistered data. This is the
// single place where the vendor ROM primitive sits; this model computes the
// same offset-binary table the init file holds.
module dds_sine_rom
    import dds_pkg::*;
#(
    parameter int    ADDR_W    = DDS_ADDR_W,
    parameter int    DATA_W    = DDS_DATA_W,
    parameter string SINE_INIT = "sine_wave_14bit_4096.mif"
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] q
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] rom_s [DEPTH];

    // A blank init file stands for an unprogrammed table reading mid-scale.
    if (SINE_INIT == "") begin : g_blank
        for (genvar i = 0; i < DEPTH; i++) begin : g_entry
            assign rom_s[i] = {1'b1, {(DATA_W-1){1'b0}}};
        end
    end else begin : g_sine
        for (genvar i = 0; i < DEPTH; i++) begin : g_entry
            assign rom_s[i] = DATA_W'(sine_sample(longint'(i), ADDR_W, DATA_W));
        end
    end

    // Address register of the synchronous ROM.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= {ADDR_W{1'b0}};
        end else begin
            addr_q <= address;
        end
    end

    assign q = rom_s[addr_q];
endmodule

// File: rtl/dds_wavegen.sv
// DDS waveform generator: phase accumulator, phase offset, four waveforms,
// double-buffered configuration applied at a phase wrap, 3-stage pipe.
module dds_wavegen
    import dds_pkg::*;
#(
    parameter int    ACC_W     = DDS_ACC_W,
    parameter int    ADDR_W    = DDS_ADDR_W,
    parameter int    DATA_W    = DDS_DATA_W,
    parameter string SINE_INIT = "sine_wave_14bit_4096.mif"
) (
    input logic          clock,
    input logic          rst_n,
    dds_wavegen_if.slave bus
);
    localparam int SHIFT = DATA_W - ADDR_W;

    logic [ACC_W-1:0]  ftw_a_q, ftw_a_d, ftw_s_q, ftw_s_d;
    logic [ADDR_W-1:0] poff_a_q, poff_a_d, poff_s_q, poff_s_d;
    logic [ADDR_W-1:0] duty_a_q, duty_a_d, duty_s_q, duty_s_d;
    mode_e             mode_a_q, mode_a_d, mode_s_q, mode_s_d;
    logic              busy_q, busy_d;

    logic [ACC_W-1:0]  acc_q, acc_d, sum_s;
    logic              carry_s, wrap_s, apply_s;
    logic              vld0_q, vld0_d, sync0_q, sync0_d;

    logic [ADDR_W-1:0] addr1_q, addr1_d, duty1_q, duty1_d;
    mode_e             mode1_q, mode1_d;
    logic              vld1_q, vld1_d, sync1_q, sync1_d;

    logic [DATA_W-1:0] sine_s, tri_base_s;
    logic [DATA_W-1:0] sine_w2_q, sine_w2_d, saw_w2_q, saw_w2_d;
    logic [DATA_W-1:0] tri_w2_q, tri_w2_d, sqr_w2_q, sqr_w2_d;
    mode_e             mode2_q, mode2_d;
    logic              vld2_q, vld2_d, sync2_q, sync2_d;

    logic [DATA_W-1:0] wave_q, wave_d;
    logic              wave_valid_q, wave_valid_d, sync_q, sync_d;

    dds_sine_rom #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .SINE_INIT (SINE_INIT)
    ) u_sine_rom (
        .clock   (clock),
        .rst_n   (rst_n),
        .address (addr1_d),
        .q       (sine_s)
    );

    // Accumulator step, wrap detection and shadow/active configuration hand-over.
    always_comb begin
        {carry_s, sum_s} = {1'b0, acc_q} + {1'b0, ftw_a_q};
        wrap_s  = bus.en & carry_s;
        // Without a wrap to wait for (halted or zero FTW) apply on the next edge.
        apply_s = busy_q & (wrap_s | ~bus.en | (ftw_a_q == {ACC_W{1'b0}}));
        acc_d   = bus.en ? sum_s : acc_q;
        vld0_d  = bus.en;
        sync0_d = wrap_s;

        ftw_a_d  = ftw_a_q;
        poff_a_d = poff_a_q;
        duty_a_d = duty_a_q;
        mode_a_d = mode_a_q;
        ftw_s_d  = ftw_s_q;
        poff_s_d = poff_s_q;
        duty_s_d = duty_s_q;
        mode_s_d = mode_s_q;
        busy_d   = busy_q;

        if (apply_s) begin
            ftw_a_d  = ftw_s_q;
            poff_a_d = poff_s_q;
            duty_a_d = duty_s_q;
            mode_a_d = mode_s_q;
            busy_d   = 1'b0;
        end else begin
            busy_d   = busy_q;
        end

        // A load on the apply edge lands in shadow and waits for the next wrap.
        if (bus.cfg_load) begin
            ftw_s_d  = bus.cfg_ftw;
            poff_s_d = bus.cfg_poff;
            duty_s_d = bus.cfg_duty;
            mode_s_d = mode_e'(bus.cfg_mode);
            busy_d   = 1'b1;
        end else begin
            ftw_s_d  = ftw_s_q;
        end
    end

    // Address stage and waveform computation; mode/duty/flags ride along.
    always_comb begin
        addr1_d = acc_q[ACC_W-1 -: ADDR_W] + poff_a_q;
        duty1_d = duty_a_q;
        mode1_d = mode_a_q;
        vld1_d  = vld0_q;
        sync1_d = sync0_q;

        tri_base_s = DATA_W'({addr1_q[ADDR_W-2:0], 1'b0}) << SHIFT;
        sine_w2_d  = sine_s;
        saw_w2_d   = DATA_W'(addr1_q) << SHIFT;
        if (addr1_q[ADDR_W-1]) begin
            tri_w2_d = ~tri_base_s;
        end else begin
            tri_w2_d = tri_base_s;
        end
        if (addr1_q < duty1_q) begin
            sqr_w2_d = {DATA_W{1'b1}};
        end else begin
            sqr_w2_d = {DATA_W{1'b0}};
        end
        mode2_d = mode1_q;
        vld2_d  = vld1_q;
        sync2_d = sync1_q;
    end

    // Output stage: select the waveform the sample was generated for.
    always_comb begin
        wave_d       = {DATA_W{1'b0}};
        wave_valid_d = vld2_q;
        sync_d       = sync2_q;
        case (mode2_q)
            MODE_SINE: wave_d = sine_w2_q;
            MODE_SAW:  wave_d = saw_w2_q;
            MODE_TRI:  wave_d = tri_w2_q;
            MODE_SQR:  wave_d = sqr_w2_q;
            default:   wave_d = {DATA_W{1'b0}};
        endcase
    end

    // All state, cleared asynchronously including pending shadow values.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            ftw_a_q      <= {ACC_W{1'b0}};
            poff_a_q     <= {ADDR_W{1'b0}};
            duty_a_q     <= {ADDR_W{1'b0}};
            mode_a_q     <= MODE_SINE;
            ftw_s_q      <= {ACC_W{1'b0}};
            poff_s_q     <= {ADDR_W{1'b0}};
            duty_s_q     <= {ADDR_W{1'b0}};
            mode_s_q     <= MODE_SINE;
            busy_q       <= 1'b0;
            acc_q        <= {ACC_W{1'b0}};
            vld0_q       <= 1'b0;
            sync0_q      <= 1'b0;
            addr1_q      <= {ADDR_W{1'b0}};
            duty1_q      <= {ADDR_W{1'b0}};
            mode1_q      <= MODE_SINE;
            vld1_q       <= 1'b0;
            sync1_q      <= 1'b0;
            sine_w2_q    <= {DATA_W{1'b0}};
            saw_w2_q     <= {DATA_W{1'b0}};
            tri_w2_q     <= {DATA_W{1'b0}};
            sqr_w2_q     <= {DATA_W{1'b0}};
            mode2_q      <= MODE_SINE;
            vld2_q       <= 1'b0;
            sync2_q      <= 1'b0;
            wave_q       <= {DATA_W{1'b0}};
            wave_valid_q <= 1'b0;
            sync_q       <= 1'b0;
        end else begin
            ftw_a_q      <= ftw_a_d;
            poff_a_q     <= poff_a_d;
            duty_a_q     <= duty_a_d;
            mode_a_q     <= mode_a_d;
            ftw_s_q      <= ftw_s_d;
            poff_s_q     <= poff_s_d;
            duty_s_q     <= duty_s_d;
            mode_s_q     <= mode_s_d;
            busy_q       <= busy_d;
            acc_q        <= acc_d;
            vld0_q       <= vld0_d;
            sync0_q      <= sync0_d;
            addr1_q      <= addr1_d;
            duty1_q      <= duty1_d;
            mode1_q      <= mode1_d;
            vld1_q       <= vld1_d;
            sync1_q      <= sync1_d;
            sine_w2_q    <= sine_w2_d;
            saw_w2_q     <= saw_w2_d;
            tri_w2_q     <= tri_w2_d;
            sqr_w2_q     <= sqr_w2_d;
            mode2_q      <= mode2_d;
            vld2_q       <= vld2_d;
            sync2_q      <= sync2_d;
            wave_q       <= wave_d;
            wave_valid_q <= wave_valid_d;
            sync_q       <= sync_d;
        end
    end

    assign bus.wave       = wave_q;
    assign bus.wave_valid = wave_valid_q;
    assign bus.sync       = sync_q;
    assign bus.cfg_busy   = busy_q;
endmodule
